// File: rtl/srio_user_pkg.sv
// Shared definitions for the SRIO user-side generator/checker pair:
// error-bit indices, last-beat keep decode, LFSR constants and FSM encoding.
package srio_user_pkg;

    localparam int ERR_DATA  = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_KEEP  = 2;
    localparam int ERR_FRAME = 3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as a mask over state bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  err;
        logic [19:0] len;
        logic [33:0] addr;
    } close_t;

    function automatic logic [3:0] err_bit(input int idx);
        return 4'b0001 << idx;
    endfunction

    // Byte enables are MSB-first, so a partial last qword keeps the top bytes.
    function automatic logic [7:0] last_keep(input logic [2:0] lo);
        return 8'hff << (3'd7 - lo);
    endfunction

endpackage

// File: rtl/user_rx_checker_if.sv
// Target-side user stream: 64-bit qword beats with first/last framing,
// MSB-first byte enables, and size/address sideband valid on the first beat.
interface user_rx_checker_if;
    logic        user_tvalid_in;
    logic        user_tready_o;
    logic [63:0] user_tdata_in;
    logic [7:0]  user_tkeep_in;
    logic        user_tfirst_in;
    logic        user_tlast_in;
    logic [19:0] user_tsize_in;
    logic [33:0] user_addr_in;

    modport master (
        output user_tvalid_in, user_tdata_in, user_tkeep_in, user_tfirst_in,
               user_tlast_in, user_tsize_in, user_addr_in,
        input  user_tready_o
    );

    modport slave (
        input  user_tvalid_in, user_tdata_in, user_tkeep_in, user_tfirst_in,
               user_tlast_in, user_tsize_in, user_addr_in,
        output user_tready_o
    );
endinterface

// File: rtl/srio_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pattern the receive ready signal.
module srio_lfsr16
    import srio_user_pkg::*;
(
    input  logic        log_clk,
    input  logic        log_rst,
    output logic [15:0] state
);

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/user_rx_checker.sv
// Receive-side checker for NWRITE user data: pattern, length and keep checks
// with per-packet status and saturating counters. USER_RX_BACKPRESSURE_EN adds LFSR-paced ready.
module user_rx_checker
    import srio_user_pkg::*;
#(
    parameter int PKT_CNT_W = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 log_clk,
    input  logic                 log_rst,
    user_rx_checker_if.slave     rx,
    output logic                 pkt_done_o,
    output logic                 pkt_err_o,
    output logic [3:0]           err_code_o,
    output logic [19:0]          last_len_o,
    output logic [33:0]          last_addr_o,
    output logic [PKT_CNT_W-1:0] pkt_cnt_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_t      state_q, state_n;
    logic [16:0] k_q, k_n;
    logic [19:0] tsize_q, tsize_n;
    logic [33:0] addr_q, addr_n;
    logic [3:0]  err_q, err_n;
    logic        tready_q, tready_d;

    logic        beat, start, do_check;
    logic [16:0] ck_k;
    logic [19:0] ck_size;
    logic [33:0] ck_addr;
    logic [3:0]  ck_err, ck_err_n;
    logic        final_beat;
    logic [7:0]  exp_keep;

    logic        close_a_v, close_b_v, emit_v, pend_v, pend_v_n;
    close_t      close_a, close_b, emit, pend_q, pend_n;

`ifdef USER_RX_BACKPRESSURE_EN
    logic [15:0] lfsr;
    srio_lfsr16 u_lfsr (
        .log_clk (log_clk),
        .log_rst (log_rst),
        .state   (lfsr)
    );
    assign tready_d = lfsr[0] | lfsr[1];
`else
    assign tready_d = 1'b1;
`endif

    assign rx.user_tready_o = tready_q;
    assign beat     = rx.user_tvalid_in && tready_q;
    // A tfirst beat opens a packet from IDLE and also from RECV (after a framing close).
    assign start    = beat && rx.user_tfirst_in && (state_q != DISCARD);
    assign do_check = start || (beat && state_q == RECV);

    // Per-beat checks run against either the fresh sideband or the open packet.
    always_comb begin
        ck_k     = start ? 17'd0 : k_q;
        ck_size  = start ? rx.user_tsize_in : tsize_q;
        ck_addr  = start ? rx.user_addr_in : addr_q;
        ck_err   = start ? 4'd0 : err_q;
        final_beat = (ck_k == ck_size[19:3]);
        exp_keep = final_beat ? last_keep(ck_size[2:0]) : 8'hff;
        ck_err_n = ck_err;
        if (rx.user_tdata_in != ({47'd0, ck_k} + 64'd1)) ck_err_n = ck_err_n | err_bit(ERR_DATA);
        if (rx.user_tkeep_in != exp_keep)                ck_err_n = ck_err_n | err_bit(ERR_KEEP);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_n   = state_q;
        k_n       = k_q;
        tsize_n   = tsize_q;
        addr_n    = addr_q;
        err_n     = err_q;
        close_a_v = 1'b0;
        close_a   = '0;
        close_b_v = 1'b0;
        close_b   = '0;

        if (beat) begin
            case (state_q)
                IDLE: begin
                    if (!rx.user_tfirst_in) begin
                        close_a_v    = 1'b1;
                        close_a.err  = err_bit(ERR_FRAME);
                        close_a.addr = rx.user_addr_in;
                    end
                end
                RECV: begin
                    if (rx.user_tfirst_in) begin
                        close_a_v    = 1'b1;
                        close_a.err  = err_q | err_bit(ERR_FRAME);
                        close_a.len  = {3'd0, k_q};
                        close_a.addr = addr_q;
                    end
                end
                DISCARD: begin
                    if (rx.user_tlast_in) begin
                        close_a_v    = 1'b1;
                        close_a.err  = err_q;
                        close_a.len  = {3'd0, tsize_q[19:3]} + 20'd1;
                        close_a.addr = addr_q;
                        state_n      = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (do_check) begin
            tsize_n = ck_size;
            addr_n  = ck_addr;
            if (rx.user_tlast_in) begin
                close_b_v    = 1'b1;
                close_b.err  = final_beat ? ck_err_n : (ck_err_n | err_bit(ERR_LEN));
                close_b.len  = {3'd0, ck_k} + 20'd1;
                close_b.addr = ck_addr;
                state_n      = IDLE;
            end else if (final_beat) begin
                err_n   = ck_err_n | err_bit(ERR_LEN);
                k_n     = ck_k;
                state_n = DISCARD;
            end else begin
                err_n   = ck_err_n;
                k_n     = ck_k + 17'd1;
                state_n = RECV;
            end
        end
    end

    // A tfirst+tlast beat in RECV closes two packets at once; the younger waits one cycle.
    always_comb begin
        emit_v   = pend_v | close_a_v | close_b_v;
        emit     = pend_v ? pend_q : (close_a_v ? close_a : close_b);
        pend_v_n = 1'b0;
        pend_n   = pend_q;
        if (pend_v && close_a_v) begin
            pend_v_n = 1'b1;
            pend_n   = close_a;
        end else if ((pend_v || close_a_v) && close_b_v) begin
            pend_v_n = 1'b1;
            pend_n   = close_b;
        end
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            tsize_q     <= '0;
            addr_q      <= '0;
            err_q       <= '0;
            pend_v      <= 1'b0;
            pend_q      <= '0;
            tready_q    <= 1'b0;
            pkt_done_o  <= 1'b0;
            pkt_err_o   <= 1'b0;
            err_code_o  <= '0;
            last_len_o  <= '0;
            last_addr_o <= '0;
            pkt_cnt_o   <= '0;
            err_cnt_o   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_n;
            k_q        <= k_n;
            tsize_q    <= tsize_n;
            addr_q     <= addr_n;
            err_q      <= err_n;
            pend_v     <= pend_v_n;
            pend_q     <= pend_n;
            tready_q   <= tready_d;
            pkt_done_o <= emit_v;
            pkt_err_o  <= emit_v && (|emit.err);
            if (emit_v) begin
                err_code_o  <= emit.err;
                last_len_o  <= emit.len;
                last_addr_o <= emit.addr;
                if (|emit.err) begin
                    if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                end else begin
                    if (pkt_cnt_o != '1) pkt_cnt_o <= pkt_cnt_o + PKT_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_user_rx_checker.sv
// Scoreboard bench for user_rx_checker: directed packets push expected closes,
// a monitor pops and compares on every pkt_done_o pulse.
module tb_user_rx_checker;
    import srio_user_pkg::*;

    localparam int PKT_CNT_W = 32;
    localparam int ERR_CNT_W = 3;
    localparam logic [63:0] ERR_MAX = (64'd1 << ERR_CNT_W) - 64'd1;

    typedef struct {
        logic [3:0]  err;
        logic [19:0] len;
        logic [33:0] addr;
        logic [63:0] pkt;
        logic [63:0] errc;
    } exp_t;

    logic                 log_clk = 1'b0;
    logic                 log_rst = 1'b1;
    logic                 pkt_done_o, pkt_err_o;
    logic [3:0]           err_code_o;
    logic [19:0]          last_len_o;
    logic [33:0]          last_addr_o;
    logic [PKT_CNT_W-1:0] pkt_cnt_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_pkt = '0;
    logic [63:0] m_err = '0;

    user_rx_checker_if rx_if ();

    user_rx_checker #(.PKT_CNT_W(PKT_CNT_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .log_clk     (log_clk),
        .log_rst     (log_rst),
        .rx          (rx_if),
        .pkt_done_o  (pkt_done_o),
        .pkt_err_o   (pkt_err_o),
        .err_code_o  (err_code_o),
        .last_len_o  (last_len_o),
        .last_addr_o (last_addr_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 log_clk = ~log_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_close(input logic [3:0] err, input logic [19:0] len, input logic [33:0] addr);
        exp_t e;
        if (err == 4'd0) m_pkt = m_pkt + 64'd1;
        else if (m_err != ERR_MAX) m_err = m_err + 64'd1;
        e.err = err; e.len = len; e.addr = addr; e.pkt = m_pkt; e.errc = m_err;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input bit first,
                             input bit last, input logic [19:0] size, input logic [33:0] addr);
        bit ok;
        bit done;
        rx_if.user_tvalid_in = 1'b1;
        rx_if.user_tdata_in  = data;
        rx_if.user_tkeep_in  = keep;
        rx_if.user_tfirst_in = first;
        rx_if.user_tlast_in  = last;
        rx_if.user_tsize_in  = size;
        rx_if.user_addr_in   = addr;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            ok = rx_if.user_tready_o;
            @(negedge log_clk);
            if (ok) done = 1'b1;
        end
        if (!done) check("beat_accept", 64'd0, 64'd1);
        rx_if.user_tvalid_in = 1'b0;
        rx_if.user_tfirst_in = 1'b0;
        rx_if.user_tlast_in  = 1'b0;
    endtask

    task automatic send_pkt(input logic [19:0] size, input logic [33:0] addr, input int nbeats,
                            input bit last_at_end, input logic [7:0] last_kp);
        for (int k = 0; k < nbeats; k++)
            send_beat(64'(k + 1), (k == nbeats - 1) ? last_kp : 8'hff, k == 0,
                      last_at_end && (k == nbeats - 1), size, addr);
    endtask

    always @(negedge log_clk) begin
        if (!log_rst && pkt_done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pkt_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("err_code", 64'(err_code_o), 64'(e.err));
                check("pkt_err", 64'(pkt_err_o), 64'(|e.err));
                check("last_len", 64'(last_len_o), 64'(e.len));
                check("last_addr", 64'(last_addr_o), 64'(e.addr));
                check("pkt_cnt", 64'(pkt_cnt_o), e.pkt);
                check("err_cnt", 64'(err_cnt_o), e.errc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.user_tvalid_in = 1'b0;
        rx_if.user_tdata_in  = '0;
        rx_if.user_tkeep_in  = '0;
        rx_if.user_tfirst_in = 1'b0;
        rx_if.user_tlast_in  = 1'b0;
        rx_if.user_tsize_in  = '0;
        rx_if.user_addr_in   = '0;

        repeat (3) @(negedge log_clk);
        check("rst_tready", 64'(rx_if.user_tready_o), 64'd0);
        check("rst_done", 64'(pkt_done_o), 64'd0);
        check("rst_err_code", 64'(err_code_o), 64'd0);
        check("rst_last_len", 64'(last_len_o), 64'd0);
        check("rst_last_addr", 64'(last_addr_o), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        log_rst = 1'b0;
        @(negedge log_clk);
        check("tready_after_rst", 64'(rx_if.user_tready_o), 64'd1);

        // 255 bytes: 32 qwords, last keep 8'hfe.
        expect_close(4'b0000, 20'd32, 34'h1_0000_0100);
        send_pkt(20'd254, 34'h1_0000_0100, 32, 1'b1, 8'hfe);

        // Single full qword.
        expect_close(4'b0000, 20'd1, 34'h0_0000_0200);
        send_pkt(20'd7, 34'h0_0000_0200, 1, 1'b1, 8'hff);

        // Short: tlast on beat 8 of 10.
        expect_close(4'b0010, 20'd8, 34'h0_0000_0300);
        send_pkt(20'd79, 34'h0_0000_0300, 8, 1'b1, 8'hff);

        // Long: no tlast on beat 2 of 2, discard beats 3-4.
        expect_close(4'b0010, 20'd2, 34'h0_0000_0400);
        send_pkt(20'd15, 34'h0_0000_0400, 2, 1'b0, 8'hff);
        send_beat(64'd3, 8'hff, 1'b0, 1'b0, 20'd0, 34'd0);
        send_beat(64'd4, 8'hff, 1'b0, 1'b1, 20'd0, 34'd0);

        // 37 bytes: bad data on beat 3, last keep ff instead of f8.
        expect_close(4'b0101, 20'd5, 34'h0_0000_0500);
        send_beat(64'd1, 8'hff, 1'b1, 1'b0, 20'd36, 34'h0_0000_0500);
        send_beat(64'd2, 8'hff, 1'b0, 1'b0, 20'd36, 34'h0_0000_0500);
        send_beat(64'd7, 8'hff, 1'b0, 1'b0, 20'd36, 34'h0_0000_0500);
        send_beat(64'd4, 8'hff, 1'b0, 1'b0, 20'd36, 34'h0_0000_0500);
        send_beat(64'd5, 8'hff, 1'b0, 1'b1, 20'd36, 34'h0_0000_0500);

        // Stray beat in IDLE.
        expect_close(4'b1000, 20'd0, 34'h0_0000_0600);
        send_beat(64'd9, 8'hff, 1'b0, 1'b0, 20'd7, 34'h0_0000_0600);

        // tfirst after two beats of a 4-qword packet, new 2-qword packet clean.
        expect_close(4'b1000, 20'd2, 34'h0_0000_0700);
        expect_close(4'b0000, 20'd2, 34'h0_0000_0800);
        send_pkt(20'd31, 34'h0_0000_0700, 2, 1'b0, 8'hff);
        send_pkt(20'd15, 34'h0_0000_0800, 2, 1'b1, 8'hff);

        // tfirst+tlast single-beat packet interrupting an open packet: two closes.
        expect_close(4'b1000, 20'd1, 34'h0_0000_0900);
        expect_close(4'b0000, 20'd1, 34'h0_0000_0a00);
        send_pkt(20'd31, 34'h0_0000_0900, 1, 1'b0, 8'hff);
        send_pkt(20'd7, 34'h0_0000_0a00, 1, 1'b1, 8'hff);

        // Two more errored packets push the 3-bit error counter past 7.
        expect_close(4'b1000, 20'd0, 34'h0_0000_0b00);
        send_beat(64'd1, 8'hff, 1'b0, 1'b0, 20'd0, 34'h0_0000_0b00);
        expect_close(4'b1000, 20'd0, 34'h0_0000_0c00);
        send_beat(64'd1, 8'hff, 1'b0, 1'b0, 20'd0, 34'h0_0000_0c00);
        repeat (3) @(negedge log_clk);
        check("err_cnt_saturated", 64'(err_cnt_o), ERR_MAX);

        // Reset in the middle of a packet.
        send_pkt(20'd63, 34'h0_0000_0d00, 3, 1'b0, 8'hff);
        log_rst = 1'b1;
        #1;
        check("midrst_tready", 64'(rx_if.user_tready_o), 64'd0);
        check("midrst_err_code", 64'(err_code_o), 64'd0);
        check("midrst_last_len", 64'(last_len_o), 64'd0);
        check("midrst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
        m_pkt = '0;
        m_err = '0;
        @(negedge log_clk);
        log_rst = 1'b0;
        @(negedge log_clk);
        check("midrst_no_done", 64'(pkt_done_o), 64'd0);

        expect_close(4'b0000, 20'd1, 34'h0_0000_0e00);
        send_pkt(20'd7, 34'h0_0000_0e00, 1, 1'b1, 8'hff);

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge log_clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_rx_checker.md
# user_rx_checker

Receive-side counterpart of the NWRITE user-data generator. Sits on the SRIO target user interface and consumes each inbound packet as a stream of 64-bit qwords. Checks payload pattern, length against the announced size, and last-beat byte enables. Reports per-packet completion and error status plus running packet and error counters for the debug register block.

## Interface
- PKT_CNT_W, 32, width of the good-packet counter
- ERR_CNT_W, 16, width of the error-packet counter
- Reset `log_rst`, asynchronous, active-high; clock `log_clk`.
- log_clk  in  1  logic clock
- log_rst  in  1  asynchronous active-high reset
- user_tvalid_in  in  1  beat valid
- user_tready_o  out  1  beat accept; a beat transfers when valid && ready
- user_tdata_in  in  64  payload qword
- user_tkeep_in  in  8  byte enables, MSB = first byte
- user_tfirst_in  in  1  first beat of packet
- user_tlast_in  in  1  last beat of packet
- user_tsize_in  in  20  packet byte count minus 1; sampled on the first beat only
- user_addr_in  in  34  target address; sampled on the first beat only
- pkt_done_o  out  1  one-cycle pulse per closed packet
- pkt_err_o  out  1  qualifies pkt_done_o; packet had at least one error
- err_code_o  out  4  sticky per-packet error bits, valid with pkt_done_o
- last_len_o  out  20  qwords received in the last closed packet
- last_addr_o  out  34  address of the last closed packet
- pkt_cnt_o  out  PKT_CNT_W  error-free packets, saturating
- err_cnt_o  out  ERR_CNT_W  errored packets, saturating

## Operation
- Beat acceptance: a transfer occurs on each log_clk edge where user_tvalid_in && user_tready_o.
- Expected qwords per packet: E = tsize[19:3] + 1, where N = tsize + 1 bytes.
- Expected keep on the last beat: if tsize[2:0]==7, 8'hff. Otherwise the top (tsize[2:0]+1) bits are set: 80, c0, e0, f0, f8, fc, fe. Keep on all other beats must be 8'hff.
- Expected data on beat k (k from 0 within the packet): 64-bit value k+1.
- err_code bits:
  - [0] data mismatch
  - [1] length mismatch
  - [2] keep mismatch
  - [3] framing
- States:
  - IDLE:
    - A beat with tfirst latches tsize and addr, clears the beat count and err_code, and checks beat 0.
    - If that beat also has tlast, the packet closes at once. Otherwise go to RECV.
    - A beat without tfirst is discarded. It produces pkt_done_o with pkt_err_o=1 and err_code=4'b1000, and the state stays IDLE.
  - RECV:
    - Each beat is checked and the count is incremented.
    - tlast with count == E closes the packet, and the keep check is applied.
    - tlast with count < E closes the packet with bit1 set.
    - Count reaching E without tlast sets bit1 and goes to DISCARD.
    - tfirst in RECV: the current packet closes with bit3 set. That beat then starts a new packet, processed exactly as in IDLE and in the same cycle.
  - DISCARD:
    - Beats are accepted without checking.
    - tlast closes the packet with its recorded errors and returns to IDLE.
- Close:
  - pkt_done_o pulses.
  - pkt_err_o = |err_code.
  - Exactly one of pkt_cnt_o or err_cnt_o increments, and it holds at its all-ones value.

## Timing
- Reset values:
  - user_tready_o=0, pkt_done_o=0, pkt_err_o=0.
  - err_code_o=0, last_len_o=0, last_addr_o=0.
  - Both counters 0; state IDLE.
- user_tready_o is registered. It goes high on the first log_clk edge after log_rst falls. In the baseline build it then stays high.
- pkt_done_o, pkt_err_o, err_code_o, last_len_o, last_addr_o and the counters update on the edge following the closing beat's acceptance, i.e. 1-cycle latency.
- Status outputs other than the pulses hold until the next close.
- The beat counter is 17 bits. E maxes at 131072; the compare uses the full width, so there is no wrap.
- A reset mid-packet discards the partial packet with no pulse, and all outputs return to their reset values.

## Configuration
- USER_RX_BACKPRESSURE_EN defined: user_tready_o = lfsr[0] | lfsr[1], registered, giving a 75% duty pattern.
  - The LFSR is a 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed 16'hACE1.
  - It advances every cycle out of reset.
  - user_tready_o is still 0 during reset.
- Undefined: no LFSR is present and user_tready_o is constant 1 after reset.

## Structure
- Shared package srio_user_pkg holds:
  - error-bit index constants ERR_DATA, ERR_LEN, ERR_KEEP, ERR_FRAME
  - the last-keep decode function of tsize[2:0]
  - LFSR seed and taps
  - the state encoding IDLE/RECV/DISCARD
- One sub-module, srio_lfsr16, instantiated only under USER_RX_BACKPRESSURE_EN.

## Test plan
- tsize=254 (255 bytes), beats data 1..32, last keep 8'hfe, tlast on beat 32 -> one pkt_done_o, pkt_err_o=0, last_len_o=32, pkt_cnt_o=1.
- tsize=7, single beat with tfirst+tlast, data 1, keep 8'hff -> pkt_err_o=0, last_len_o=1.
- tsize=79, tlast on beat 8 of 10 -> err_code_o=4'b0010, err_cnt_o=1. Then tsize=15 with tlast missing on beat 2 and beats 3-4 with tlast on 4 -> second error, last_len_o=2 (beats counted to E), err_cnt_o=2.
- tsize=36, beat 3 data 64'h7, last keep 8'hff -> err_code_o=4'b0101.
- Beat without tfirst in IDLE -> err_code_o=4'b1000. tfirst in the middle of a packet -> old packet closes with bit3, and the new packet completes cleanly.
- log_rst asserted mid-packet -> no pulse, counters 0; next clean packet counts 1. With USER_RX_BACKPRESSURE_EN, repeat the first case and require an identical result.
